fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage of the 16-bit pipeline: owns the PC, a 2-bit-counter branch
//   history table (BHT), and the IF/ID pipeline register. Feeds IFID and Predict to
//   hazard_ctrl. Consumes PCStall, plus MP and correct_pc from hazard_ctrl/EX, to
//   stall, redirect and flush.
// PARAMETERS
//   PC_W    16       PC / instruction-memory address width (word addressed)
//   IDX_W   4        BHT index width; 2**IDX_W entries, indexed by PC[IDX_W-1:0]
//   BR_OP   4'b1000  opcode (instr[15:12]) of conditional branch
//   NOP     16'h0000 instruction injected into IF/ID on flush
// PORTS
//   clock          in   1      system clock, all state on rising edge
//   reset          in   1      asynchronous, active-low; 0 clears all state immediately
//   imem_addr      out  PC_W   current PC to instruction memory (equals PC register)
//   imem_data      in   16     instruction at imem_addr, combinational same-cycle
//   PCStall        in   1      hold PC and IF/ID (from hazard_ctrl)
//   MP             in   1      misprediction: redirect PC to correct_pc, flush IF/ID
//   correct_pc     in   PC_W   redirect target, valid when MP=1
//   resolve_valid  in   1      branch resolved in EX this cycle (BHT update strobe)
//   resolve_pc     in   PC_W   PC of the resolved branch
//   resolve_taken  in   1      actual outcome of the resolved branch
//   IFID           out  16     instruction in IF/ID register
//   IFID_pc        out  PC_W   PC of instruction in IF/ID
//   IFID_valid     out  1      0 = bubble (reset or flush)
//   Predict        out  1      predicted-taken flag for instruction in IF/ID
//   mp_count       out  8      saturating count of MP assertions since reset
// BEHAVIOUR
//   Reset (reset=0): PC=0, IFID=NOP, IFID_pc=0, IFID_valid=0, Predict=0,
//     mp_count=0, every BHT entry=2'b01 (weakly not-taken).
//   Fetch decode (combinational): is_br = (imem_data[15:12]==BR_OP);
//     tgt = PC + 1 + sext(imem_data[7:0]), mod 2**PC_W;
//     pred = is_br & BHT[PC[IDX_W-1:0]][1].
//   Per rising edge, priority order:
//     1. MP=1: PC<=correct_pc; IFID<=NOP, IFID_valid<=0, Predict<=0, IFID_pc<=0.
//        MP overrides PCStall.
//     2. PCStall=1: PC, IFID, IFID_pc, IFID_valid and Predict all hold.
//     3. else: IFID<=imem_data, IFID_pc<=PC, IFID_valid<=1, Predict<=pred;
//        PC<= pred ? tgt : PC+1.
//   Latency: instruction at PC appears on IFID one edge later. A predicted-taken
//     branch costs no bubble.
//   PC+1 and tgt wrap modulo 2**PC_W without a flag, e.g. PC=16'hFFFF -> 16'h0000.
//   BHT update on resolve_valid=1, independent of PCStall and MP:
//     entry[resolve_pc[IDX_W-1:0]]: taken -> saturating increment to max 2'b11;
//     not taken -> saturating decrement to min 2'b00.
//   Same-cycle lookup and update of one index: lookup sees the pre-update value.
//     The write lands at the edge.
//   mp_count increments on each edge with MP=1 and saturates at 8'hFF.
//   reset asserted mid-operation: all state returns to reset values immediately
//     (asynchronous). First fetch is at PC=0 on the first edge after release.
// TESTING
//   T1 reset: hold reset=0, then release; imem[0]=16'h6103
//     -> imem_addr=0 before the first edge; after edge 1 IFID=16'h6103, IFID_valid=1,
//     Predict=0, PC=1.
//   T2 stall: PCStall=1 for 3 cycles at PC=5
//     -> PC stays 5; IFID/IFID_pc/Predict unchanged; advances on the first edge after release.
//   T3 training: branch 16'h8004 at PC=2; resolve_valid=1, resolve_pc=2, resolve_taken=1
//     for 2 cycles -> BHT[2]=2'b11; the next fetch of PC=2 gives Predict=1 and next PC=7.
//   T4 flush priority: MP=1, PCStall=1, correct_pc=16'h0020 on the same edge
//     -> PC=16'h0020, IFID=16'h0000, IFID_valid=0, mp_count increments by 1.
//   T5 saturation: 4 not-taken updates to index 3 -> BHT[3]=2'b00 and stays there;
//     300 MP pulses -> mp_count=8'hFF.
//   T6 wrap: PC=16'hFFFF, non-branch instruction, no stall -> PC=16'h0000;
//     branch at 16'hFFFE with offset 8'h05, predicted taken -> PC=16'h0004.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, 2-bit-counter branch history table and
// the IF/ID pipeline register, with stall, misprediction redirect and flush.
module fetch_stage #(
  parameter int          PC_W  = 16,
  parameter int          IDX_W = 4,
  parameter logic [3:0]  BR_OP = 4'b1000,
  parameter logic [15:0] NOP   = 16'h0000
) (
  input  logic            clock,
  input  logic            reset,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic            PCStall,
  input  logic            MP,
  input  logic [PC_W-1:0] correct_pc,
  input  logic            resolve_valid,
  input  logic [PC_W-1:0] resolve_pc,
  input  logic            resolve_taken,
  output logic [15:0]     IFID,
  output logic [PC_W-1:0] IFID_pc,
  output logic            IFID_valid,
  output logic            Predict,
  output logic [7:0]      mp_count
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  tgt;
  logic [1:0]       bht [ENTRIES];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             is_br;
  logic             pred;

  // Address bits above the table index and the unused immediate field are
  // deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{resolve_pc[PC_W-1:IDX_W], imem_data[11:8]};

  assign imem_addr = pc;
  assign fetch_idx = pc[IDX_W-1:0];
  assign upd_idx   = resolve_pc[IDX_W-1:0];

  assign is_br  = (imem_data[15:12] == BR_OP);
  assign pc_inc = pc + PC_W'(1);
  assign tgt    = pc_inc + {{(PC_W-8){imem_data[7]}}, imem_data[7:0]};
  // Lookup reads the table before this edge's update lands.
  assign pred   = is_br & bht[fetch_idx][1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc         <= '0;
      IFID       <= NOP;
      IFID_pc    <= '0;
      IFID_valid <= 1'b0;
      Predict    <= 1'b0;
    end else if (MP) begin
      pc         <= correct_pc;
      IFID       <= NOP;
      IFID_pc    <= '0;
      IFID_valid <= 1'b0;
      Predict    <= 1'b0;
    end else if (!PCStall) begin
      pc         <= pred ? tgt : pc_inc;
      IFID       <= imem_data;
      IFID_pc    <= pc;
      IFID_valid <= 1'b1;
      Predict    <= pred;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mp_count <= '0;
    end else if (MP && (mp_count != 8'hFF)) begin
      mp_count <= mp_count + 8'd1;
    end
  end

  // NOTE: the history table must start weakly not-taken, so every entry is
  // reset explicitly; it is small enough to live in flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (resolve_valid) begin
      if (resolve_taken) begin
        if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'b01;
      end else begin
        if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'b01;
      end
    end
  end

endmodule
